aes_subshift_serial: RTL
========================

# aes_subshift_serial

Area-optimised SubBytes + ShiftRows stage of the AES encryption round datapath. It sits directly upstream of the combinational MixColumns stage. It accepts a 128-bit state over a valid/ready handshake and substitutes its bytes through a shared computed S-box over several cycles. It then presents the ShiftRows-permuted result, held stable, on a valid/ready output whose data feeds MixColumns' `state_in`.

## Interface
- No parameters; throughput mode is selected by the macro in Configuration.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream offers `state_in`.
- `in_ready` out 1: stage can accept; equals (state == IDLE).
- `state_in` in 128: AES state, column-major; byte k = 4*col+row at bits [127-8k -: 8].
- `out_valid` out 1: `state_out` is valid and held.
- `out_ready` in 1: downstream accepts `state_out`.
- `state_out` out 128: ShiftRows(SubBytes(`state_in`)), same byte ordering.
- `busy` out 1: high in SUB or DONE.

## Operation
- Internal state: 128-bit buffer, byte counter `cnt`, FSM with states IDLE, SUB and DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, capture `state_in` into the buffer, clear `cnt`, and go to SUB.
- SUB: on each edge, replace buffer bytes with their S-box images. Bytes advance in index order 0..15.
  - Serial build: 1 byte per edge (`cnt` 0..15).
  - Four-S-box build: 4 bytes per edge (bytes 4c..4c+3, `cnt` 0..3).
  - The edge that processes the last byte moves the FSM to DONE and sets `out_valid`.
- S-box: GF(2^8) multiplicative inverse (0 maps to 0) under polynomial 0x11B, followed by the FIPS-197 affine transform with constant 0x63. Purely combinational.
- DONE: `out_valid`=1. `state_out` is a combinational ShiftRows of the buffer: out byte (4c+r) = buffer byte (4*((c+r) mod 4)+r). On `out_valid && out_ready`, clear `out_valid` and return to IDLE.
- `state_out` is driven from the buffer in every state. It is defined only while `out_valid`=1.
- `in_valid` is ignored outside IDLE; no second block is accepted while busy.
- Upstream may change `state_in` freely after the accepting edge.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - FSM = IDLE, `cnt` = 0, buffer = 0.
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1, `state_out` = 0.
- Reset asserted mid-operation aborts the block with no output. The first accept after release is processed normally.
- Latency, with the accept edge at the end of cycle T:
  - Serial: `out_valid` first high in cycle T+17.
  - Four-S-box: `out_valid` first high in cycle T+5.
- `out_valid` stays high and `state_out` stays stable until the handshake cycle.
- Minimum accept-to-accept period with `out_ready` held high:
  - Serial: 18 cycles.
  - Four-S-box: 6 cycles.
- Output handshake and next input accept never occur in the same cycle.
- `out_ready` high before `out_valid` has no effect.

## Configuration
- `AES_SUBSHIFT_FOUR_SBOX_EN`
  - Defined: four S-box instances, 4 SUB cycles, `cnt` 2 bits.
  - Undefined: one S-box instance, 16 SUB cycles, `cnt` 4 bits.
- Functional results are identical in both builds; only latency and throughput differ.
- The bench runs every scenario in both builds.

## Test plan
- Known-answer (FIPS-197 App. B round 1): `state_in`=193de3bea0f4e22b9ac68d2ae9f84808 -> `state_out`=d4bf5d30e0b452aeb84111f11e2798e5. Feeding this to MixColumns must give 046681e5e0cb199a48f8d37a2806264c.
- S-box corners: all-zero input -> 16×63. Input 00010203…0e0f -> bytes S(00)=63 and S(01)=7c at their ShiftRows positions. Input containing 53 and ff -> ed and 16 in the correct positions.
- Backpressure: hold `out_ready`=0 for 10 cycles after `out_valid`, toggling `in_valid` and `state_in` -> `state_out` stable, `in_ready`=0, no new accept. Release -> one handshake, then IDLE.
- Back-to-back: 8 random blocks with `in_valid` and `out_ready` held high -> outputs match the reference model in order, with an accept period of exactly 18 (serial) or 6 (four-S-box) cycles.
- Reset mid-SUB: assert `rst_n`=0 at SUB cycle 7 for 1 cycle -> `out_valid` never rises for that block. The next block accepted after release produces the correct result at the nominal latency.
- Latency check: accept at cycle T -> `out_valid` low through T+16 and high at T+17 (serial); low through T+4 and high at T+5 (four-S-box).

Source files
------------

// File: rtl/aes_subshift_serial_if.sv
// Handshake bundle for the AES SubBytes + ShiftRows stage.
//   master : upstream/downstream side (drives in_valid, state_in, out_ready)
//   slave  : the stage itself (drives in_ready, out_valid, state_out, busy)
// Byte k of a state (k = 4*col + row) sits at bits [127-8k -: 8].
interface aes_subshift_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/aes_subshift_serial.sv
// Area-optimised AES SubBytes + ShiftRows stage. A 128-bit state is captured,
// its bytes are pushed through a shared computed S-box in index order, and the
// ShiftRows-permuted buffer is held on the output until downstream takes it.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : aes_subshift_serial_if.slave (in_valid/in_ready/state_in,
//            out_valid/out_ready/state_out, busy)
//
// Build option:
//   AES_SUBSHIFT_FOUR_SBOX_EN defined   : four S-boxes, 4 SUB cycles, 2-bit cnt
//   AES_SUBSHIFT_FOUR_SBOX_EN undefined : one S-box, 16 SUB cycles, 4-bit cnt
//
// state | meaning
// IDLE  | waiting for a block, in_ready high
// SUB   | substituting bytes, NSB per cycle
// DONE  | result held on state_out, out_valid high
module aes_subshift_serial (
  input logic                 clk,
  input logic                 rst_n,
  aes_subshift_serial_if.slave bus
);

`ifdef AES_SUBSHIFT_FOUR_SBOX_EN
  localparam int NSB = 4;
  localparam int CW  = 2;
`else
  localparam int NSB = 1;
  localparam int CW  = 4;
`endif

  localparam logic [CW-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // buf_q[15-k] is byte k, so the packed vector lines up with state_in bits.
  logic [15:0][7:0]     buf_q, buf_d;
  logic [15:0][7:0]     shifted;
  logic [3:0]           idx;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); 0 falls out as 0 with no special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    return gf_mul(x252, x2);
  endfunction

  // Affine step: bit i XORs bits i, i+4..i+7 (mod 8), i.e. rotate-left 0..4.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    idx     = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d   = bus.state_in;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int j = 0; j < NSB; j++) begin
`ifdef AES_SUBSHIFT_FOUR_SBOX_EN
          idx = {cnt_q, 2'(j)};
`else
          idx = cnt_q;
`endif
          buf_d[4'd15 - idx] = sbox(buf_q[4'd15 - idx]);
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == '1) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // out byte (4c+r) takes buffer byte 4*((c+r) mod 4)+r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[15 - (4*c + r)] = buf_q[15 - (4*((c + r) % 4) + r)];
    end
  end

  assign bus.state_out = shifted;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == SUB) || (state_q == DONE);

endmodule
